// File: rtl/fm_mem_arbiter_pkg.sv
// Shared types for the feature-map memory arbiter: owner modes, arbiter
// states and the packed feature-map word.
package fm_mem_arbiter_pkg;

    // Which engine currently owns the feature-map BRAM
    typedef enum logic {
        CONVOLUTION = 1'b0,
        POOLING     = 1'b1
    } arbiter_mode_t;

    // Ownership hand-over sequence
    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } arbiter_state_t;

    localparam int FM_OUT_CHANNELS    = 2;
    localparam int FM_BITS_PER_NEURON = 9;
    localparam int FM_DATA_WIDTH      = FM_OUT_CHANNELS * FM_BITS_PER_NEURON;

    // One BRAM word: all output channels' neuron states packed together
    typedef logic [FM_DATA_WIDTH-1:0] fm_word_t;

endpackage

// File: rtl/fm_mem_arbiter_if.sv
// Bundle of the arbiter's mode handshake, both engine ports, the BRAM port
// and the access counters. "slave" is the arbiter's view, "master" the
// view of the cores/memory surrounding it.
interface fm_mem_arbiter_if
    import fm_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 18,
    parameter int CNT_WIDTH  = 16
) ();

    logic                  mode_req;
    arbiter_mode_t         mode_target;
    logic                  mode_ack;
    arbiter_mode_t         mode_o;

    logic                  conv_valid;
    logic                  conv_ready;
    logic                  conv_we;
    logic [ADDR_WIDTH-1:0] conv_addr;
    logic [DATA_WIDTH-1:0] conv_wdata;
    logic                  conv_rvalid;
    logic [DATA_WIDTH-1:0] conv_rdata;

    logic                  pool_valid;
    logic                  pool_ready;
    logic                  pool_we;
    logic [ADDR_WIDTH-1:0] pool_addr;
    logic [DATA_WIDTH-1:0] pool_wdata;
    logic                  pool_rvalid;
    logic [DATA_WIDTH-1:0] pool_rdata;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic [CNT_WIDTH-1:0]  conv_cnt;
    logic [CNT_WIDTH-1:0]  pool_cnt;

    modport slave (
        input  mode_req, mode_target,
        output mode_ack, mode_o,
        input  conv_valid, conv_we, conv_addr, conv_wdata,
        output conv_ready, conv_rvalid, conv_rdata,
        input  pool_valid, pool_we, pool_addr, pool_wdata,
        output pool_ready, pool_rvalid, pool_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output conv_cnt, pool_cnt
    );

    modport master (
        output mode_req, mode_target,
        input  mode_ack, mode_o,
        output conv_valid, conv_we, conv_addr, conv_wdata,
        input  conv_ready, conv_rvalid, conv_rdata,
        output pool_valid, pool_we, pool_addr, pool_wdata,
        input  pool_ready, pool_rvalid, pool_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  conv_cnt, pool_cnt
    );

endinterface

// File: rtl/fm_mem_arbiter_rd_tag_pipe.sv
// Read-tag shift register: tracks which engine issued each outstanding
// BRAM read so the returning data can be steered, and reports how many
// reads are still in flight.
module fm_mem_arbiter_rd_tag_pipe
    import fm_mem_arbiter_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int INFLIGHT_W   = $clog2(READ_LATENCY + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  arbiter_mode_t         i_mode,
    output logic                  o_valid,
    output arbiter_mode_t         o_mode,
    output logic [INFLIGHT_W-1:0] o_inflight
);

    logic          r_vld  [READ_LATENCY];
    arbiter_mode_t r_mode [READ_LATENCY];
    logic [INFLIGHT_W-1:0] w_inflight;

    // Shift the {valid, owner} tag one stage per cycle; reset drops all tags
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_vld[i]  <= 1'b0;
                r_mode[i] <= CONVOLUTION;
            end
        end else begin
            r_vld[0]  <= i_valid;
            r_mode[0] <= i_mode;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_mode[i] <= r_mode[i-1];
            end
        end
    end

    // Population count of valid tags across every stage
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_inflight = w_inflight + INFLIGHT_W'(r_vld[i]);
        end
    end

    assign o_valid    = r_vld[READ_LATENCY-1];
    assign o_mode     = r_mode[READ_LATENCY-1];
    assign o_inflight = w_inflight;

endmodule

// File: rtl/fm_mem_arbiter.sv
// Time-shares one single-port feature-map BRAM between the convolution and
// pooling engines. One engine owns the port at a time; switching owner is a
// req/ack handshake that first lets outstanding reads return.
module fm_mem_arbiter
    import fm_mem_arbiter_pkg::*;
#(
    parameter int OUT_CHANNELS    = 2,
    parameter int BITS_PER_NEURON = 9,
    parameter int DATA_WIDTH      = OUT_CHANNELS * BITS_PER_NEURON,
    parameter int ADDR_WIDTH      = 6,
    parameter int READ_LATENCY    = 2,
    parameter int CNT_WIDTH       = 16
) (
    input  logic              clk,
    input  logic              rst,
    fm_mem_arbiter_if.slave   bus
);

    localparam int INFLIGHT_W = $clog2(READ_LATENCY + 1);

    arbiter_state_t        r_state;
    arbiter_mode_t         r_mode_o;
    arbiter_mode_t         r_target;
    logic                  r_mode_ack;
    logic [CNT_WIDTH-1:0]  r_conv_cnt;
    logic [CNT_WIDTH-1:0]  r_pool_cnt;
    logic [DATA_WIDTH-1:0] r_conv_rdata;
    logic [DATA_WIDTH-1:0] r_pool_rdata;

    logic                  w_xswitch;
    logic                  w_conv_ready;
    logic                  w_pool_ready;
    logic                  w_conv_acc;
    logic                  w_pool_acc;
    logic                  w_acc;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_rd_acc;
    arbiter_mode_t         w_rd_mode;
    logic                  w_out_vld;
    arbiter_mode_t         w_out_mode;
    logic [INFLIGHT_W-1:0] w_inflight;
    logic                  w_drained;
    logic                  w_conv_rvalid;
    logic                  w_pool_rvalid;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // A pending cross-mode request blocks new accesses so the pipe can drain
    assign w_xswitch    = bus.mode_req && (bus.mode_target != r_mode_o);
    assign w_conv_ready = (r_state == ACTIVE) && (r_mode_o == CONVOLUTION) && !w_xswitch;
    assign w_pool_ready = (r_state == ACTIVE) && (r_mode_o == POOLING) && !w_xswitch;
    assign w_conv_acc   = bus.conv_valid && w_conv_ready;
    assign w_pool_acc   = bus.pool_valid && w_pool_ready;
    assign w_acc        = w_conv_acc || w_pool_acc;

    assign w_sel_we    = w_pool_acc ? bus.pool_we    : bus.conv_we;
    assign w_sel_addr  = w_pool_acc ? bus.pool_addr  : bus.conv_addr;
    assign w_sel_wdata = w_pool_acc ? bus.pool_wdata : bus.conv_wdata;

    assign bus.mem_en    = w_acc;
    assign bus.mem_we    = w_acc && w_sel_we;
    assign bus.mem_addr  = w_acc ? w_sel_addr  : '0;
    assign bus.mem_wdata = w_acc ? w_sel_wdata : '0;

    assign w_rd_acc  = w_acc && !w_sel_we;
    assign w_rd_mode = w_pool_acc ? POOLING : CONVOLUTION;

    fm_mem_arbiter_rd_tag_pipe #(
        .READ_LATENCY (READ_LATENCY),
        .INFLIGHT_W   (INFLIGHT_W)
    ) u_rd_tag_pipe (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (w_rd_acc),
        .i_mode     (w_rd_mode),
        .o_valid    (w_out_vld),
        .o_mode     (w_out_mode),
        .o_inflight (w_inflight)
    );

    // A read sitting at the pipe output returns this cycle, so only earlier
    // stages can still hold up the hand-over.
    assign w_drained = (w_inflight == INFLIGHT_W'(w_out_vld));

    assign w_conv_rvalid = w_out_vld && (w_out_mode == CONVOLUTION);
    assign w_pool_rvalid = w_out_vld && (w_out_mode == POOLING);

    assign bus.conv_ready  = w_conv_ready;
    assign bus.pool_ready  = w_pool_ready;
    assign bus.conv_rvalid = w_conv_rvalid;
    assign bus.pool_rvalid = w_pool_rvalid;
    assign bus.conv_rdata  = w_conv_rvalid ? bus.mem_rdata : r_conv_rdata;
    assign bus.pool_rdata  = w_pool_rvalid ? bus.mem_rdata : r_pool_rdata;
    assign bus.mode_ack    = r_mode_ack;
    assign bus.mode_o      = r_mode_o;
    assign bus.conv_cnt    = r_conv_cnt;
    assign bus.pool_cnt    = r_pool_cnt;

    // Ownership FSM: same-mode requests ack at once, cross-mode ones drain first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ACTIVE;
            r_mode_o   <= CONVOLUTION;
            r_target   <= CONVOLUTION;
            r_mode_ack <= 1'b0;
        end else begin
            r_mode_ack <= 1'b0;
            case (r_state)
                ACTIVE: begin
                    if (bus.mode_req && !r_mode_ack) begin
                        if (bus.mode_target == r_mode_o) begin
                            r_mode_ack <= 1'b1;
                        end else begin
                            r_target <= bus.mode_target;
                            r_state  <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_drained) begin
                        r_mode_o   <= r_target;
                        r_mode_ack <= 1'b1;
                        r_state    <= SWITCH;
                    end
                end
                SWITCH: begin
                    r_state <= ACTIVE;
                end
                default: begin
                    r_state <= ACTIVE;
                end
            endcase
        end
    end

    // Per-engine accepted-access counters, saturating at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conv_cnt <= '0;
            r_pool_cnt <= '0;
        end else begin
            if (w_conv_acc) r_conv_cnt <= sat_inc(r_conv_cnt);
            if (w_pool_acc) r_pool_cnt <= sat_inc(r_pool_cnt);
        end
    end

    // Each engine's read data holds its last returned word between reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conv_rdata <= '0;
            r_pool_rdata <= '0;
        end else begin
            if (w_conv_rvalid) r_conv_rdata <= bus.mem_rdata;
            if (w_pool_rvalid) r_pool_rdata <= bus.mem_rdata;
        end
    end

    // The requester must keep mode_req up until the hand-over is acknowledged
    a_req_held: assert property (@(posedge clk) disable iff (rst)
        (r_state == DRAIN) |-> bus.mode_req);

endmodule

// File: tb/tb_fm_mem_arbiter.sv
// Directed bench for fm_mem_arbiter with a 2-cycle-latency BRAM model.
module tb_fm_mem_arbiter;
    import fm_mem_arbiter_pkg::*;

    localparam int AW = 6;
    localparam int DW = 18;
    localparam int CW = 4;
    localparam int RL = 2;

    logic clk = 1'b0;
    logic rst;
    logic init;
    int   n_checks = 0;
    int   n_errors = 0;

    fm_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    fm_mem_arbiter #(
        .OUT_CHANNELS    (2),
        .BITS_PER_NEURON (9),
        .ADDR_WIDTH      (AW),
        .READ_LATENCY    (RL),
        .CNT_WIDTH       (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int a);
        return (a == 5) ? 18'h1A5 : DW'(32'h100 + a);
    endfunction

    // BRAM model: write-first storage, read data two clocks after enable
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd_p0;
    logic [DW-1:0] rd_p1;
    always @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= init_val(i);
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            rd_p0 <= mem[bus.mem_addr];
        end
        rd_p1 <= rd_p0;
    end
    assign bus.mem_rdata = rd_p1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic idle;
        bus.conv_valid = 1'b0; bus.conv_we = 1'b0; bus.conv_addr = '0; bus.conv_wdata = '0;
        bus.pool_valid = 1'b0; bus.pool_we = 1'b0; bus.pool_addr = '0; bus.pool_wdata = '0;
    endtask

    task automatic conv_drive(input logic we, input int addr, input logic [DW-1:0] wd);
        bus.conv_valid = 1'b1; bus.conv_we = we; bus.conv_addr = AW'(addr); bus.conv_wdata = wd;
    endtask

    task automatic pool_drive(input logic we, input int addr, input logic [DW-1:0] wd);
        bus.pool_valid = 1'b1; bus.pool_we = we; bus.pool_addr = AW'(addr); bus.pool_wdata = wd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        init = 1'b1;
        bus.mode_req = 1'b0;
        bus.mode_target = CONVOLUTION;
        idle();
        tick(); tick();
        settle();
        chk("rst_mode_o",   bus.mode_o, CONVOLUTION);
        chk("rst_ack",      bus.mode_ack, 0);
        chk("rst_crvalid",  bus.conv_rvalid, 0);
        chk("rst_prvalid",  bus.pool_rvalid, 0);
        chk("rst_ccnt",     bus.conv_cnt, 0);
        chk("rst_pcnt",     bus.pool_cnt, 0);
        chk("rst_mem_en",   bus.mem_en, 0);
        chk("rst_crdata",   bus.conv_rdata, 0);
        rst = 1'b0;
        init = 1'b0;
        tick();

        // Single conv read of addr 5
        conv_drive(1'b0, 5, '0); settle();
        chk("t1_ready", bus.conv_ready, 1);
        chk("t1_en",    bus.mem_en, 1);
        chk("t1_addr",  bus.mem_addr, 5);
        tick();
        idle(); settle();
        chk("t1_rv_early", bus.conv_rvalid, 0);
        tick(); settle();
        chk("t1_rvalid", bus.conv_rvalid, 1);
        chk("t1_rdata",  bus.conv_rdata, 18'h1A5);
        chk("t1_prv",    bus.pool_rvalid, 0);
        tick(); settle();
        chk("t1_rv_off", bus.conv_rvalid, 0);
        chk("t1_hold",   bus.conv_rdata, 18'h1A5);
        chk("t1_cnt",    bus.conv_cnt, 1);

        // Same-mode request: ack next cycle, accesses keep flowing
        bus.mode_req = 1'b1; bus.mode_target = CONVOLUTION;
        conv_drive(1'b0, 1, '0); settle();
        chk("t3_ready", bus.conv_ready, 1);
        chk("t3_ack0",  bus.mode_ack, 0);
        tick(); settle();
        chk("t3_ack1",  bus.mode_ack, 1);
        chk("t3_mode",  bus.mode_o, CONVOLUTION);
        bus.mode_req = 1'b0; idle();
        tick(); settle();
        chk("t3_ack_off", bus.mode_ack, 0);
        chk("t3_rvalid",  bus.conv_rvalid, 1);
        chk("t3_rdata",   bus.conv_rdata, 18'h101);

        // Non-owner request is ignored
        pool_drive(1'b0, 9, '0); settle();
        chk("t4_pready", bus.pool_ready, 0);
        chk("t4_en",     bus.mem_en, 0);
        tick();
        idle(); settle();
        chk("t4_pcnt", bus.pool_cnt, 0);
        chk("t4_prv",  bus.pool_rvalid, 0);
        chk("t4_ccnt", bus.conv_cnt, 2);

        // Burst of conv reads then switch to pooling with drain
        for (int i = 0; i < 4; i++) begin
            conv_drive(1'b0, i, '0); settle();
            chk("t2_ready", bus.conv_ready, 1);
            if (i >= 2) begin
                chk("t2_rv",  bus.conv_rvalid, 1);
                chk("t2_rd",  bus.conv_rdata, init_val(i - 2));
            end
            tick();
        end
        bus.mode_req = 1'b1; bus.mode_target = POOLING;
        conv_drive(1'b0, 4, '0); settle();
        chk("t2_refuse_rdy", bus.conv_ready, 0);
        chk("t2_refuse_en",  bus.mem_en, 0);
        chk("t2_rv2",        bus.conv_rvalid, 1);
        chk("t2_rd2",        bus.conv_rdata, init_val(2));
        tick();
        idle(); settle();
        chk("t2_rv3",      bus.conv_rvalid, 1);
        chk("t2_rd3",      bus.conv_rdata, init_val(3));
        chk("t2_drain_cr", bus.conv_ready, 0);
        chk("t2_drain_pr", bus.pool_ready, 0);
        chk("t2_drain_ak", bus.mode_ack, 0);
        chk("t2_drain_md", bus.mode_o, CONVOLUTION);
        tick(); settle();
        chk("t2_ack",     bus.mode_ack, 1);
        chk("t2_mode",    bus.mode_o, POOLING);
        chk("t2_sw_pr",   bus.pool_ready, 0);
        chk("t2_sw_rv",   bus.conv_rvalid, 0);
        bus.mode_req = 1'b0;
        tick(); settle();
        chk("t2_ack_off", bus.mode_ack, 0);
        chk("t2_pready",  bus.pool_ready, 1);
        chk("t2_cready",  bus.conv_ready, 0);
        chk("t2_ccnt",    bus.conv_cnt, 6);

        // Pool reads, then reset while reads are outstanding
        pool_drive(1'b0, 5, '0); settle();
        chk("t6_en", bus.mem_en, 1);
        tick();
        pool_drive(1'b0, 0, '0);
        tick();
        pool_drive(1'b0, 1, '0); settle();
        chk("t6_prv",   bus.pool_rvalid, 1);
        chk("t6_prd",   bus.pool_rdata, 18'h1A5);
        chk("t6_crv",   bus.conv_rvalid, 0);
        chk("t6_chold", bus.conv_rdata, init_val(3));
        tick();
        pool_drive(1'b0, 2, '0); settle();
        chk("t6_prv2", bus.pool_rvalid, 1);
        chk("t6_prd2", bus.pool_rdata, 18'h100);
        chk("t6_pcnt", bus.pool_cnt, 3);
        rst = 1'b1;
        idle(); settle();
        chk("t6_rst_prv",  bus.pool_rvalid, 0);
        chk("t6_rst_mode", bus.mode_o, CONVOLUTION);
        chk("t6_rst_pcnt", bus.pool_cnt, 0);
        chk("t6_rst_ccnt", bus.conv_cnt, 0);
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t6_post_crv", bus.conv_rvalid, 0);
            chk("t6_post_prv", bus.pool_rvalid, 0);
            tick();
        end
        chk("t6_prdata0", bus.pool_rdata, 0);
        chk("t6_cready",  bus.conv_ready, 1);

        // Write then read back addr 7
        conv_drive(1'b1, 7, 18'h0FF); settle();
        chk("t5_we",    bus.mem_we, 1);
        chk("t5_wdata", bus.mem_wdata, 18'h0FF);
        chk("t5_addr",  bus.mem_addr, 7);
        tick();
        conv_drive(1'b0, 7, '0); settle();
        chk("t5_rd_we", bus.mem_we, 0);
        chk("t5_rd_en", bus.mem_en, 1);
        tick();
        idle(); settle();
        chk("t5_no_wrv", bus.conv_rvalid, 0);
        tick(); settle();
        chk("t5_rvalid", bus.conv_rvalid, 1);
        chk("t5_rdata",  bus.conv_rdata, 18'h0FF);
        chk("t5_cnt",    bus.conv_cnt, 2);

        // Counter saturation with a 4-bit counter
        for (int i = 0; i < 15; i++) begin
            conv_drive(1'b1, 10 + i, DW'(i));
            tick();
        end
        idle(); settle();
        chk("sat_ccnt", bus.conv_cnt, 4'hF);
        chk("sat_pcnt", bus.pool_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
